// File: rtl/finder_pkg.sv
// Shared types and default sizing for the finder-pattern bounds scanner.
package finder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam int DEF_N_LINES  = 480;
    localparam int DEF_MAX_RUNS = 3;
    localparam int DEF_MIN_RUN  = 4;

endpackage

// File: rtl/run_scanner.sv
// One axis of the bounds finder: tracks runs of set flags one line per step
// and accumulates bounds, centres, run count and overflow.
module run_scanner
    import finder_pkg::*;
#(
    parameter int N_LINES  = DEF_N_LINES,
    parameter int IDX_W    = $clog2(N_LINES),
    parameter int MAX_RUNS = DEF_MAX_RUNS,
    parameter int MIN_RUN  = DEF_MIN_RUN,
    localparam int CNT_W   = $clog2(MAX_RUNS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           step,
    input  logic                           line_bit,
    input  logic [IDX_W-1:0]               idx,
    input  logic                           last,
    output logic [1:0][IDX_W-1:0]          bound,
    output logic [MAX_RUNS-1:0][IDX_W-1:0] centre,
    output logic [CNT_W-1:0]               count,
    output logic                           overflow
);

    logic             run_open;
    logic [IDX_W-1:0] run_start;
    logic             close_run;
    logic             accept;
    logic [IDX_W-1:0] seg_start;
    logic [IDX_W-1:0] seg_end;
    logic [IDX_W:0]   seg_len;
    logic [IDX_W:0]   seg_sum;

    // A set bit on the final line closes whatever is open, or a 1-line run.
    always_comb begin
        close_run = 1'b0;
        seg_start = run_start;
        seg_end   = idx;
        if (step) begin
            if (line_bit && last) begin
                close_run = 1'b1;
                seg_start = run_open ? run_start : idx;
            end else if (!line_bit && run_open) begin
                close_run = 1'b1;
                seg_end   = idx - IDX_W'(1);
            end
        end
        seg_len = {1'b0, seg_end} - {1'b0, seg_start} + (IDX_W + 1)'(1);
        seg_sum = {1'b0, seg_start} + {1'b0, seg_end};
        accept  = close_run && (seg_len >= (IDX_W + 1)'(MIN_RUN));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_open  <= 1'b0;
            run_start <= '0;
            bound     <= '0;
            centre    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else if (step) begin
            if (line_bit && !run_open && !last) begin
                run_open  <= 1'b1;
                run_start <= idx;
            end else if (close_run) begin
                run_open  <= 1'b0;
            end
            if (accept) begin
                if (count == '0) begin
                    bound[0] <= seg_start;
                end
                bound[1] <= seg_end;
                if (count < CNT_W'(MAX_RUNS)) begin
                    centre[count] <= seg_sum[IDX_W:1];
                    count         <= count + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/finder_bounds.sv
// Finds run bounds and centres on both axes of the finder-pattern flags,
// scanning one line per cycle from a snapshot taken at start.
module finder_bounds
    import finder_pkg::*;
#(
    parameter int N_LINES  = DEF_N_LINES,
    parameter int IDX_W    = $clog2(N_LINES),
    parameter int MAX_RUNS = DEF_MAX_RUNS,
    parameter int MIN_RUN  = DEF_MIN_RUN,
    localparam int CNT_W   = $clog2(MAX_RUNS + 1)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [N_LINES-1:0]             horz_patterns,
    input  logic [N_LINES-1:0]             vert_patterns,
    input  logic                           start_bound,
    output logic                           busy,
    output logic                           valid_bound,
    output logic [1:0][IDX_W-1:0]          bound_x,
    output logic [1:0][IDX_W-1:0]          bound_y,
    output logic [MAX_RUNS-1:0][IDX_W-1:0] centre_x,
    output logic [MAX_RUNS-1:0][IDX_W-1:0] centre_y,
    output logic [CNT_W-1:0]               count_x,
    output logic [CNT_W-1:0]               count_y,
    output logic                           overflow_x,
    output logic                           overflow_y
);

    state_t               state;
    state_t               next;
    logic [IDX_W-1:0]     idx;
    logic [N_LINES-1:0]   horz_snap;
    logic [N_LINES-1:0]   vert_snap;
    logic                 last;
    logic                 accept_start;

    logic [1:0][IDX_W-1:0]          wx_bound, wy_bound, hx_bound, hy_bound;
    logic [MAX_RUNS-1:0][IDX_W-1:0] wx_centre, wy_centre, hx_centre, hy_centre;
    logic [CNT_W-1:0]               wx_count, wy_count, hx_count, hy_count;
    logic                           wx_ovf, wy_ovf, hx_ovf, hy_ovf;

    assign last         = (idx == IDX_W'(N_LINES - 1));
    assign accept_start = (state == IDLE) && start_bound;
    assign busy         = (state == SCAN);
    assign valid_bound  = (state == DONE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (start_bound) next = SCAN;
            SCAN:    if (last) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx       <= '0;
            horz_snap <= '0;
            vert_snap <= '0;
        end else if (accept_start) begin
            idx       <= '0;
            horz_snap <= horz_patterns;
            vert_snap <= vert_patterns;
        end else if (busy && !last) begin
            idx <= idx + IDX_W'(1);
        end
    end

    run_scanner #(
        .N_LINES (N_LINES),
        .IDX_W   (IDX_W),
        .MAX_RUNS(MAX_RUNS),
        .MIN_RUN (MIN_RUN)
    ) u_scan_x (
        .clk     (clk_in),
        .rst     (rst_in),
        .clear   (accept_start),
        .step    (busy),
        .line_bit(vert_snap[idx]),
        .idx     (idx),
        .last    (last),
        .bound   (wx_bound),
        .centre  (wx_centre),
        .count   (wx_count),
        .overflow(wx_ovf)
    );

    run_scanner #(
        .N_LINES (N_LINES),
        .IDX_W   (IDX_W),
        .MAX_RUNS(MAX_RUNS),
        .MIN_RUN (MIN_RUN)
    ) u_scan_y (
        .clk     (clk_in),
        .rst     (rst_in),
        .clear   (accept_start),
        .step    (busy),
        .line_bit(horz_snap[idx]),
        .idx     (idx),
        .last    (last),
        .bound   (wy_bound),
        .centre  (wy_centre),
        .count   (wy_count),
        .overflow(wy_ovf)
    );

    // Held copies keep the last result visible while a new scan runs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hx_bound  <= '0;
            hy_bound  <= '0;
            hx_centre <= '0;
            hy_centre <= '0;
            hx_count  <= '0;
            hy_count  <= '0;
            hx_ovf    <= 1'b0;
            hy_ovf    <= 1'b0;
        end else if (valid_bound) begin
            hx_bound  <= wx_bound;
            hy_bound  <= wy_bound;
            hx_centre <= wx_centre;
            hy_centre <= wy_centre;
            hx_count  <= wx_count;
            hy_count  <= wy_count;
            hx_ovf    <= wx_ovf;
            hy_ovf    <= wy_ovf;
        end
    end

    // During DONE the fresh results are shown directly so they align with valid_bound.
    always_comb begin
        bound_x    = hx_bound;
        bound_y    = hy_bound;
        centre_x   = hx_centre;
        centre_y   = hy_centre;
        count_x    = hx_count;
        count_y    = hy_count;
        overflow_x = hx_ovf;
        overflow_y = hy_ovf;
        if (valid_bound) begin
            bound_x    = wx_bound;
            bound_y    = wy_bound;
            centre_x   = wx_centre;
            centre_y   = wy_centre;
            count_x    = wx_count;
            count_y    = wy_count;
            overflow_x = wx_ovf;
            overflow_y = wy_ovf;
        end
    end

endmodule

// File: tb/tb_finder_bounds.sv
// Bench for finder_bounds: directed and random flag vectors against a
// run-list reference model, on a MIN_RUN=4 and a MIN_RUN=1 instance.
module tb_finder_bounds;

    localparam int N = 480;
    localparam int W = 9;

    logic         clk;
    logic         rst;
    logic [N-1:0] horz;
    logic [N-1:0] vert;
    logic         start;

    logic                busy, valid, ox, oy;
    logic [1:0][W-1:0]   bx, by;
    logic [2:0][W-1:0]   cx, cy;
    logic [1:0]          nx, ny;
    logic                busy1, valid1, ox1, oy1;
    logic [1:0][W-1:0]   bx1, by1;
    logic [2:0][W-1:0]   cx1, cy1;
    logic [1:0]          nx1, ny1;

    logic [47:0] got[4];
    logic [47:0] exp_r[4];
    logic [191:0] outs;
    int  vcyc;
    bit  busy_ok, pulse_ok, rst_zero;
    int  checks = 0;
    int  passes = 0;

    finder_bounds dut (
        .clk_in(clk), .rst_in(rst),
        .horz_patterns(horz), .vert_patterns(vert),
        .start_bound(start), .busy(busy), .valid_bound(valid),
        .bound_x(bx), .bound_y(by), .centre_x(cx), .centre_y(cy),
        .count_x(nx), .count_y(ny), .overflow_x(ox), .overflow_y(oy)
    );

    finder_bounds #(.MIN_RUN(1)) dut1 (
        .clk_in(clk), .rst_in(rst),
        .horz_patterns(horz), .vert_patterns(vert),
        .start_bound(start), .busy(busy1), .valid_bound(valid1),
        .bound_x(bx1), .bound_y(by1), .centre_x(cx1), .centre_y(cy1),
        .count_x(nx1), .count_y(ny1), .overflow_x(ox1), .overflow_y(oy1)
    );

    assign outs = {busy, valid, bx, by, cx, cy, nx, ny, ox, oy,
                   busy1, valid1, bx1, by1, cx1, cy1, nx1, ny1, ox1, oy1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: list maximal runs, filter by length, then summarise.
    function automatic logic [47:0] model(input logic [N-1:0] v, input int minr);
        int b0 = 0, b1 = 0, n = 0, i = 0, s;
        int cen[3] = '{0, 0, 0};
        bit ovf = 1'b0;
        while (i < N) begin
            if (!v[i]) begin
                i++;
                continue;
            end
            s = i;
            while (i < N && v[i]) i++;
            if (i - s >= minr) begin
                if (n == 0) b0 = s;
                b1 = i - 1;
                if (n < 3) cen[n] = (s + i - 1) / 2;
                else ovf = 1'b1;
                n++;
            end
        end
        return {W'(b1), W'(b0), W'(cen[2]), W'(cen[1]), W'(cen[0]),
                2'(n > 3 ? 3 : n), ovf};
    endfunction

    function automatic logic [N-1:0] span(input logic [N-1:0] v, input int a, input int b);
        for (int i = a; i <= b; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v = '0;
        int nr = $urandom_range(0, 6);
        for (int k = 0; k < nr; k++) begin
            int s = $urandom_range(0, N - 1);
            int l = $urandom_range(1, 40);
            for (int j = s; j < s + l && j < N; j++) v[j] = 1'b1;
        end
        return v;
    endfunction

    // Starts one scan and records what the DUTs show; called at #1 after an edge.
    task automatic run_scan(input logic [N-1:0] h, input logic [N-1:0] v,
                            input int chg_cyc, input int rst_cyc);
        bit eb;
        exp_r[0] = model(v, 4);
        exp_r[1] = model(h, 4);
        exp_r[2] = model(v, 1);
        exp_r[3] = model(h, 1);
        vcyc = -1;
        busy_ok = 1'b1;
        pulse_ok = 1'b1;
        rst_zero = 1'b0;
        horz = h;
        vert = v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            eb = (cyc <= 480) && (rst_cyc == 0 || cyc <= rst_cyc);
            if (busy !== eb || busy1 !== eb) busy_ok = 1'b0;
            if (valid === 1'b1 && vcyc < 0) begin
                vcyc = cyc;
                got[0] = {bx, cx, nx, ox};
                got[1] = {by, cy, ny, oy};
                got[2] = {bx1, cx1, nx1, ox1};
                got[3] = {by1, cy1, ny1, oy1};
            end else if (vcyc > 0 && cyc == vcyc + 1) begin
                if (valid !== 1'b0 || {bx, cx, nx, ox} !== got[0]) pulse_ok = 1'b0;
                break;
            end
            if (cyc == chg_cyc) begin
                horz = ~h;
                vert = ~v;
                start = 1'b1;
            end
            if (cyc == chg_cyc + 1) start = 1'b0;
            if (rst_cyc > 0 && cyc == rst_cyc) rst = 1'b1;
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                rst_zero = (outs === '0);
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        horz = '1;
        vert = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs !== '0) $display("FAIL reset_outs got=%h exp=0", outs);
        else passes++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL reset_idle busy=%b valid=%b exp=0", busy, valid);
        else passes++;
    endtask

    task automatic test_three_runs();
        logic [N-1:0] v;
        v = span(span(span('0, 51, 89), 231, 269), 401, 439);
        run_scan(v, v, 0, 0);
        checks++;
        if (vcyc !== 481) $display("FAIL three_latency got=%0d exp=481", vcyc);
        else passes++;
        checks++;
        if (!busy_ok) $display("FAIL three_busy got=bad exp=cycles1..480");
        else passes++;
        checks++;
        if (!pulse_ok) $display("FAIL three_pulse got=bad exp=one_cycle");
        else passes++;
        checks++;
        if (got[0] !== {9'd439, 9'd51, 9'd420, 9'd250, 9'd70, 2'd3, 1'b0})
            $display("FAIL three_x got=%h", got[0]);
        else passes++;
        for (int a = 1; a < 4; a++) begin
            checks++;
            if (got[a] !== exp_r[a]) $display("FAIL three_res%0d got=%h exp=%h", a, got[a], exp_r[a]);
            else passes++;
        end
    endtask

    task automatic test_short_run();
        logic [N-1:0] v;
        v = span(span('0, 10, 12), 100, 119);
        run_scan(v, v, 0, 0);
        checks++;
        if (got[1] !== {9'd119, 9'd100, 9'd0, 9'd0, 9'd109, 2'd1, 1'b0})
            $display("FAIL short_y got=%h", got[1]);
        else passes++;
        for (int a = 0; a < 4; a++) begin
            checks++;
            if (got[a] !== exp_r[a]) $display("FAIL short_res%0d got=%h exp=%h", a, got[a], exp_r[a]);
            else passes++;
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] v;
        v = span(span(span(span('0, 20, 29), 120, 129), 220, 229), 320, 329);
        run_scan(v, v, 0, 0);
        checks++;
        if (got[0] !== {9'd329, 9'd20, 9'd224, 9'd124, 9'd24, 2'd3, 1'b1})
            $display("FAIL ovf_x got=%h", got[0]);
        else passes++;
        checks++;
        if (got[3] !== exp_r[3]) $display("FAIL ovf_y1 got=%h exp=%h", got[3], exp_r[3]);
        else passes++;
    endtask

    task automatic test_end_touch();
        logic [N-1:0] h;
        h = '0;
        h[N-1] = 1'b1;
        run_scan(h, span('0, 470, 479), 0, 0);
        checks++;
        if (got[0] !== {9'd479, 9'd470, 9'd0, 9'd0, 9'd474, 2'd1, 1'b0})
            $display("FAIL end_x got=%h", got[0]);
        else passes++;
        checks++;
        if (got[1] !== '0) $display("FAIL end_lone_rejected got=%h exp=0", got[1]);
        else passes++;
        checks++;
        if (got[3] !== {9'd479, 9'd479, 9'd0, 9'd0, 9'd479, 2'd1, 1'b0})
            $display("FAIL end_lone_y1 got=%h", got[3]);
        else passes++;
    endtask

    task automatic test_zero_and_snapshot();
        logic [N-1:0] h, v;
        run_scan('0, '0, 0, 0);
        checks++;
        if (vcyc !== 481 || got[0] !== '0 || got[1] !== '0)
            $display("FAIL zero got=%0d/%h/%h exp=481/0/0", vcyc, got[0], got[1]);
        else passes++;
        h = rand_vec();
        v = rand_vec();
        run_scan(h, v, 100, 0);
        checks++;
        if (vcyc !== 481) $display("FAIL snap_latency got=%0d exp=481", vcyc);
        else passes++;
        for (int a = 0; a < 4; a++) begin
            checks++;
            if (got[a] !== exp_r[a]) $display("FAIL snap_res%0d got=%h exp=%h", a, got[a], exp_r[a]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] h, v;
        h = span(span('0, 5, 60), 300, 340);
        v = span('0, 200, 250);
        run_scan(h, v, 0, 200);
        checks++;
        if (!rst_zero) $display("FAIL rstmid_zero got=nonzero exp=0");
        else passes++;
        checks++;
        if (vcyc !== -1 || !busy_ok) $display("FAIL rstmid_novalid got=%0d busy_ok=%0d exp=-1", vcyc, busy_ok);
        else passes++;
        run_scan(h, v, 0, 0);
        checks++;
        if (vcyc !== 481) $display("FAIL rstmid_restart got=%0d exp=481", vcyc);
        else passes++;
        for (int a = 0; a < 4; a++) begin
            checks++;
            if (got[a] !== exp_r[a]) $display("FAIL rstmid_res%0d got=%h exp=%h", a, got[a], exp_r[a]);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            run_scan(rand_vec(), rand_vec(), 0, 0);
            checks++;
            if (vcyc !== 481 || !busy_ok || !pulse_ok)
                $display("FAIL rand%0d_timing got=%0d/%0d/%0d exp=481/1/1", t, vcyc, busy_ok, pulse_ok);
            else passes++;
            for (int a = 0; a < 4; a++) begin
                checks++;
                if (got[a] !== exp_r[a]) $display("FAIL rand%0d_res%0d got=%h exp=%h", t, a, got[a], exp_r[a]);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        horz = span('0, 40, 80);
        vert = span('0, 90, 95);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 1100 && second < 0; cyc++) begin
            if (valid === 1'b1) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            if (second < 0) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        checks++;
        if (first !== 481 || second !== 963)
            $display("FAIL b2b got=%0d,%0d exp=481,963", first, second);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || {by, cy, ny, oy} !== model(span('0, 40, 80), 4))
            $display("FAIL b2b_idle busy=%b y=%h", busy, {by, cy, ny, oy});
        else passes++;
    endtask

    initial begin
        test_reset();
        test_three_runs();
        test_short_run();
        test_overflow();
        test_end_touch();
        test_zero_and_snapshot();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/finder_bounds.md
Name: finder_bounds

Overview:
- Scans the per-line finder-pattern flag vectors (one bit per row and one bit per column) to locate up to MAX_RUNS runs of set bits on each axis.
- Reports, per axis, the overall bounding pair (first start, last end), each run's centre, a run count and an overflow flag.
- Runs shorter than MIN_RUN are rejected as noise.
- Sits between the pattern detector and the QR sampling-grid stage. It is the parametrised successor of the fixed 480-line bounds block.

Parameters:
- N_LINES, 480, number of lines per axis (vector width).
- IDX_W, $clog2(N_LINES), index/coordinate width.
- MAX_RUNS, 3, runs stored per axis.
- MIN_RUN, 4, minimum accepted run length in lines (≥1).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- horz_patterns  input  N_LINES  row flags; bit i = line i
- vert_patterns  input  N_LINES  column flags
- start_bound  input  1  start request, sampled in IDLE only
- busy  output  1  high from the cycle after start is accepted until valid_bound
- valid_bound  output  1  one-cycle pulse when results are ready
- bound_x  output  2×IDX_W  [0]=first accepted start, [1]=last accepted end (vert axis)
- bound_y  output  2×IDX_W  same for horz axis
- centre_x, centre_y  output  MAX_RUNS×IDX_W  run centres in discovery order
- count_x, count_y  output  $clog2(MAX_RUNS+1)  accepted runs, saturating at MAX_RUNS
- overflow_x, overflow_y  output  1  more than MAX_RUNS runs were accepted

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: FSM=IDLE; all outputs 0; internal run state cleared. Reset mid-scan aborts with no valid_bound pulse.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - start_bound=1 snapshots both vectors into internal registers, sets idx=0 and goes to SCAN.
  - Input vectors may change afterwards without effect.
  - Result outputs keep their previous values until the new scan finishes.
- SCAN: each cycle examines bit idx of both snapshots in parallel, then idx++. Per axis:
  - Run opens when the bit is 1 and no run is open; run_start=idx.
  - Run closes when the bit is 0 while a run is open (end=idx-1), or when idx=N_LINES-1 with bit 1 (end=N_LINES-1). A run of one line at the final index opens and closes the same cycle.
  - A closed run is accepted iff end-start+1 ≥ MIN_RUN; otherwise it is discarded silently.
  - On acceptance:
    - First acceptance sets bound[0]=start.
    - Every acceptance sets bound[1]=end, including runs beyond MAX_RUNS.
    - If count<MAX_RUNS: centre[count]=(start+end)>>1, computed in IDX_W+1 bits then truncated. count++.
    - Else overflow=1 and count holds.
  - After idx=N_LINES-1 is processed, go to DONE.
- DONE: commits the working registers to the outputs, pulses valid_bound for one cycle, drops busy and returns to IDLE.
- Latency: start sampled at edge 0 → valid_bound high during cycle N_LINES+1 (481 for the default).
- start_bound held high re-triggers a new scan on the cycle after DONE. start_bound during SCAN or DONE is ignored.
- Zero accepted runs: bounds=0, count=0, centres=0, overflow=0, valid_bound still pulses.
- Centre slots at or above count read 0.
- Axes are independent; count_x and count_y may differ.

Decomposition:
- Package finder_pkg holds:
  - FSM enum state_t {IDLE, SCAN, DONE}
  - default constants DEF_N_LINES=480, DEF_MAX_RUNS=3, DEF_MIN_RUN=4
- Sub-module run_scanner (params N_LINES, IDX_W, MAX_RUNS, MIN_RUN):
  - one axis's open/close/accept logic, bound, centre, count and overflow registers
  - inputs: clear, step, bit, idx, last
  - instantiated twice, for x and y
- The top level owns the FSM, index counter, snapshots and output commit.

Test Plan:
1. Both vectors with bits 51..89, 231..269 and 401..439 set, start pulsed → valid_bound at cycle 481; bounds (51,439); centres 70,250,420; count 3; overflow 0; busy high for cycles 1..480.
2. Run 10..12 (length 3) plus run 100..119, MIN_RUN=4 → count 1, bounds (100,119), centre[0]=109; short run ignored.
3. Four runs 20..29, 120..129, 220..229, 320..329 → count 3; centres 24,124,224; overflow 1; bounds (20,329).
4. Run 470..479 touching the end, plus a lone bit at 479 on the other axis with MIN_RUN=1 → ends closed at 479; centres 474 and 479.
5. All-zero vectors → count 0, bounds (0,0), valid_bound pulses at 481. Vectors changed and start re-pulsed mid-scan → results reflect the snapshot, no restart.
6. rst_in asserted at scan cycle 200 → all outputs 0 next cycle, no valid_bound. A new start afterwards completes normally 481 cycles later.
